pipe_ctrl: RTL

Central stall/flush controller for the five-stage in-order pipeline. It collects hazard and busy requests from IF, ID, EX and MEM and drives the per-stage stall and flush controls consumed by the pipeline registers (pc_reg, if_id, id_ex, ex_mem). It also sequences branch redirects that race an in-flight instruction fetch, so that the stale fetch is always squashed. Optional performance counters report stall and redirect activity.

---
 rtl/pipe_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Central stall/flush controller for a five-stage in-order pipeline.
//
// It gathers hazard and busy requests from IF, ID, EX and MEM. It drives the
// per-stage hold (stall) and bubble (flush) controls consumed by pc_reg,
// if_id, id_ex and ex_mem.
//
// A small FSM sequences branch redirects that race an outstanding
// instruction fetch. This guarantees that the stale fetch result is always
// squashed.
//
// Control outputs are combinational from the current state and the inputs.
// Requests therefore take effect in the same cycle; only the state advances
// on the clock edge.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   -> saturating stall_cycles / redirect_count counters
//   undefined -> no counter flops, both counter outputs tied to zero
//
// Parameters:
//   CNT_W          width of the performance counters (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   rdy            global ready; 0 freezes the whole pipeline
//   if_busy        instruction fetch outstanding, no valid instruction
//   mem_busy       load/store in MEM not yet complete
//   id_load_use    ID source matches the rd of a load in EX
//   ex_jump        EX resolved a taken jump/branch
//   pc_stall       hold PC
//   pc_redirect    PC loads the EX target this cycle
//   if_id_stall    hold IF/ID register
//   id_ex_stall    hold ID/EX register
//   ex_mem_stall   hold EX/MEM register
//   if_id_flush    load a NOP bubble into IF/ID
//   id_ex_flush    load a NOP bubble into ID/EX
//   stall_cycles   cycles (with rdy=1) on which any stall was asserted
//   redirect_count number of redirects issued
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             id_load_use,
    input  logic             ex_jump,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    // RUN    : normal flow
    // BUBBLE : one cycle after a load-use bubble; a repeated request is the
    //          same hazard and must not insert a second bubble
    // DRAIN  : a redirect happened while a fetch was outstanding; that
    //          fetch's result is stale and must be flushed when it returns
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // Control outputs and next state, in priority order:
    // reset, !rdy, mem_busy, ex_jump, id_load_use, if_busy.
    always_comb begin
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        next_state_s = state_r;

        if (!rst) begin
            // Hold and bubble everything while in reset; never redirect.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            next_state_s = RUN;
        end else if (!rdy || mem_busy) begin
            // Global freeze or MEM wait. EX is frozen as well, so a pending
            // ex_jump stays asserted and is picked up once the freeze ends.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            next_state_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_jump) begin
                        // The jump wins over a load-use: the hazard
                        // instruction in ID is flushed anyway.
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (if_busy) begin
                            next_state_s = DRAIN;
                        end else begin
                            next_state_s = RUN;
                        end
                    end else if (id_load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_flush  = 1'b1;
                        next_state_s = BUBBLE;
                    end else if (if_busy) begin
                        pc_stall     = 1'b1;
                        if_id_flush  = 1'b1;
                        next_state_s = RUN;
                    end else begin
                        next_state_s = RUN;
                    end
                end

                BUBBLE: begin
                    // id_load_use is deliberately ignored here.
                    if (ex_jump) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (if_busy) begin
                            next_state_s = DRAIN;
                        end else begin
                            next_state_s = RUN;
                        end
                    end else if (if_busy) begin
                        pc_stall     = 1'b1;
                        if_id_flush  = 1'b1;
                        next_state_s = RUN;
                    end else begin
                        next_state_s = RUN;
                    end
                end

                DRAIN: begin
                    // Keep squashing until the stale fetch has returned. On
                    // the cycle if_busy drops, that returning result is the
                    // stale one, so it is flushed too before RUN resumes.
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (if_busy) begin
                        next_state_s = DRAIN;
                    end else begin
                        next_state_s = RUN;
                    end
                end

                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             any_stall_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] redir_cnt_r;

    assign any_stall_s = pc_stall | if_id_stall | id_ex_stall | ex_mem_stall;

    // Saturating activity counters. A freeze (rdy=0) is not counted as a
    // pipeline stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            redir_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (rdy && any_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (pc_redirect && (redir_cnt_r != CNT_MAX)) begin
                redir_cnt_r <= redir_cnt_r + CNT_ONE;
            end else begin
                redir_cnt_r <= redir_cnt_r;
            end
        end
    end

    assign stall_cycles   = stall_cnt_r;
    assign redirect_count = redir_cnt_r;
`else
    assign stall_cycles   = {CNT_W{1'b0}};
    assign redirect_count = {CNT_W{1'b0}};
`endif

endmodule
